// File: rtl/dma_fifo_wr_arb_if.sv
// Signal bundle between the producer channels, the DMA FIFO write port and
// the write arbiter. The master modport is the environment side (producers
// and FIFO). The slave modport is the arbiter.
`ifndef DMA_DATA_WIDTH
`define DMA_DATA_WIDTH 32
`endif

interface dma_fifo_wr_arb_if #(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = `DMA_DATA_WIDTH,
  parameter int LEN_W   = 8
);
  logic                          clear_i;
  logic [NUM_REQ-1:0]            req_i;
  logic [NUM_REQ-1:0][LEN_W-1:0] len_i;
  logic [NUM_REQ-1:0]            valid_i;
  logic [NUM_REQ-1:0][WIDTH-1:0] data_i;
  logic [NUM_REQ-1:0]            ready_o;
  logic [NUM_REQ-1:0]            gnt_o;
  logic                          fifo_full_i;
  logic                          fifo_write_o;
  logic [WIDTH-1:0]              fifo_data_o;
  logic                          busy_o;

  modport master (
    output clear_i, req_i, len_i, valid_i, data_i, fifo_full_i,
    input  ready_o, gnt_o, fifo_write_o, fifo_data_o, busy_o
  );

  modport slave (
    input  clear_i, req_i, len_i, valid_i, data_i, fifo_full_i,
    output ready_o, gnt_o, fifo_write_o, fifo_data_o, busy_o
  );
endinterface

// File: rtl/dma_fifo_wr_arb.sv
// Round-robin arbiter that gives one producer channel at a time ownership
// of a DMA FIFO write port for a whole burst of len+1 beats. A burst cannot
// be preempted. At least one idle arbitration cycle separates two bursts.
`ifndef DMA_DATA_WIDTH
`define DMA_DATA_WIDTH 32
`endif

module dma_fifo_wr_arb #(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = `DMA_DATA_WIDTH,
  parameter int LEN_W   = 8
) (
  input logic              clk,
  input logic              rst,
  dma_fifo_wr_arb_if.slave bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  if (NUM_REQ < 2) begin : g_num_req_too_small
    $error("dma_fifo_wr_arb: NUM_REQ must be at least 2");
  end
  if (NUM_REQ > 16) begin : g_num_req_too_large
    $error("dma_fifo_wr_arb: NUM_REQ must be at most 16");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic [IDX_W-1:0] last_gnt_q, last_gnt_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] cand;
  logic             any_req;
  logic             beat_wr;

  // Round-robin search: the first requester after the last completed owner wins.
  always_comb begin
    pick_idx = '0;
    cand     = '0;
    any_req  = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((int'(last_gnt_q) + i) % NUM_REQ);
      if (!any_req && bus.req_i[cand]) begin
        any_req  = 1'b1;
        pick_idx = cand;
      end
    end
  end

  // State, owner, remaining-beat counter and round-robin pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_idx_q  <= '0;
      cnt_q      <= '0;
      last_gnt_q <= LAST_IDX;
    end else begin
      state_q    <= state_d;
      gnt_idx_q  <= gnt_idx_d;
      cnt_q      <= cnt_d;
      last_gnt_q <= last_gnt_d;
    end
  end

  // Next-state and port steering. A clear overrides whatever the burst would do.
  always_comb begin
    state_d          = state_q;
    gnt_idx_d        = gnt_idx_q;
    cnt_d            = cnt_q;
    last_gnt_d       = last_gnt_q;
    beat_wr          = 1'b0;
    bus.gnt_o        = '0;
    bus.ready_o      = '0;
    bus.fifo_write_o = 1'b0;
    bus.fifo_data_o  = '0;
    bus.busy_o       = 1'b0;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          gnt_idx_d = pick_idx;
          cnt_d     = bus.len_i[pick_idx];
          state_d   = BURST;
        end
      end
      BURST: begin
        beat_wr                = bus.valid_i[gnt_idx_q] & ~bus.fifo_full_i;
        bus.gnt_o[gnt_idx_q]   = 1'b1;
        bus.busy_o             = 1'b1;
        bus.ready_o[gnt_idx_q] = ~bus.fifo_full_i;
        bus.fifo_write_o       = beat_wr;
        bus.fifo_data_o        = bus.data_i[gnt_idx_q];
        if (beat_wr) begin
          if (cnt_q == '0) begin
            state_d    = IDLE;
            last_gnt_d = gnt_idx_q;
          end else begin
            cnt_d = cnt_q - LEN_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (bus.clear_i) begin
      bus.ready_o      = '0;
      bus.fifo_write_o = 1'b0;
      state_d          = IDLE;
      cnt_d            = '0;
      last_gnt_d       = LAST_IDX;
    end
  end

endmodule

// File: tb/tb_dma_fifo_wr_arb.sv
// Testbench for dma_fifo_wr_arb: directed burst scenarios plus a randomized
// run checked against a transaction-level round-robin reference model.
module tb_dma_fifo_wr_arb;

  localparam int N  = 3;
  localparam int W  = 32;
  localparam int LW = 8;

  logic clk = 1'b0;
  logic rst;

  int checks   = 0;
  int failures = 0;
  int seq[N];
  int lenv[N];

  dma_fifo_wr_arb_if #(.NUM_REQ(N), .WIDTH(W), .LEN_W(LW)) bus ();

  dma_fifo_wr_arb #(.NUM_REQ(N), .WIDTH(W), .LEN_W(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, 10 ns period.
  always #5 clk = ~clk;

  // Watchdog so the run can never hang.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Beat payload of a producer: channel number in the top byte, beat sequence below it.
  function automatic logic [W-1:0] mk(input int c, input int s);
    return (32'(c) << 24) | (32'(s) & 32'h00FF_FFFF);
  endfunction

  task automatic drive_data();
    logic [N*W-1:0] flat;
    flat = '0;
    for (int c = 0; c < N; c++) flat = flat | ((N*W)'(mk(c, seq[c])) << (c * W));
    bus.data_i = flat;
  endtask

  task automatic drive_len();
    logic [N*LW-1:0] flat;
    flat = '0;
    for (int c = 0; c < N; c++) flat = flat | ((N*LW)'(lenv[c] & 255) << (c * LW));
    bus.len_i = flat;
  endtask

  // Advance one clock. Producers whose beat was accepted step to their next beat.
  task automatic edge_step();
    int hs;
    hs = int'(bus.ready_o & bus.valid_i);
    @(posedge clk);
    #1;
    for (int c = 0; c < N; c++) if (((hs >> c) & 1) != 0) seq[c]++;
    drive_data();
  endtask

  task automatic apply_reset();
    bus.req_i   = '0;
    bus.clear_i = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain(output bit ok);
    ok = 1'b0;
    bus.req_i       = '0;
    bus.valid_i     = '1;
    bus.fifo_full_i = 1'b0;
    bus.clear_i     = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (!bus.busy_o) begin
        ok = 1'b1;
        edge_step();
        break;
      end
      edge_step();
    end
  endtask

  task automatic rand_inputs();
    for (int c = 0; c < N; c++) lenv[c] = int'($urandom_range(0, 3));
    bus.req_i       = N'($urandom_range(0, (1 << N) - 1));
    bus.valid_i     = N'($urandom) | N'($urandom);
    bus.fifo_full_i = ($urandom_range(0, 4) == 0);
    bus.clear_i     = ($urandom_range(0, 49) == 0);
    drive_len();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_i = '1; bus.valid_i = '1; bus.fifo_full_i = 1'b0; bus.clear_i = 1'b0;
    for (int c = 0; c < N; c++) lenv[c] = 2;
    drive_len();
    drive_data();
    for (int pass = 0; pass < 2; pass++) begin
      @(negedge clk);
      checks++; if (bus.gnt_o !== '0) begin failures++; $display("[TB] FAIL reset_gnt pass %0d: got %b expected 000", pass, bus.gnt_o); end
      checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy pass %0d: got %b expected 0", pass, bus.busy_o); end
      checks++; if (bus.ready_o !== '0) begin failures++; $display("[TB] FAIL reset_ready pass %0d: got %b expected 000", pass, bus.ready_o); end
      checks++; if (bus.fifo_write_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_write pass %0d: got %b expected 0", pass, bus.fifo_write_o); end
      checks++; if (bus.fifo_data_o !== '0) begin failures++; $display("[TB] FAIL reset_data pass %0d: got %h expected 0", pass, bus.fifo_data_o); end
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.req_i = '0;
    end
  endtask

  task automatic test_single_burst();
    int base, nwr, first_gnt;
    base = seq[0]; nwr = 0; first_gnt = 0;
    bus.req_i = 3'b001; bus.len_i[0] = 8'd3; bus.valid_i = 3'b001; bus.fifo_full_i = 1'b0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      if (bus.gnt_o != '0) begin
        if (first_gnt == 0) first_gnt = cyc;
        checks++; if (bus.gnt_o !== 3'b001) begin failures++; $display("[TB] FAIL single_gnt cyc %0d: got %b expected 001", cyc, bus.gnt_o); end
      end
      if (bus.fifo_write_o) begin
        checks++; if (bus.fifo_data_o !== mk(0, base + nwr)) begin failures++; $display("[TB] FAIL single_data beat %0d: got %h expected %h", nwr, bus.fifo_data_o, mk(0, base + nwr)); end
        nwr++;
      end
      edge_step();
      if (first_gnt != 0) bus.req_i = '0;
    end
    checks++; if (first_gnt != 2) begin failures++; $display("[TB] FAIL single_latency: got first grant cycle %0d expected 2", first_gnt); end
    checks++; if (nwr != 4) begin failures++; $display("[TB] FAIL single_count: got %0d writes expected 4", nwr); end
    @(negedge clk);
    checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("[TB] FAIL single_idle: got busy %b expected 0", bus.busy_o); end
    edge_step();
  endtask

  task automatic test_alternate();
    logic [N-1:0] exp_gnt;
    bit ok;
    apply_reset();
    bus.req_i = 3'b011; bus.len_i = '0; bus.valid_i = '1; bus.fifo_full_i = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k % 2 == 1) exp_gnt = '0;
      else exp_gnt = (((k / 2) - 1) % 2 == 0) ? 3'b001 : 3'b010;
      checks++; if (bus.gnt_o !== exp_gnt) begin failures++; $display("[TB] FAIL alternate_gnt cyc %0d: got %b expected %b", k, bus.gnt_o, exp_gnt); end
      edge_step();
    end
    drain(ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL alternate_drain: got busy stuck expected idle"); end
  endtask

  task automatic test_full_stall();
    int base, nwr, stall_cnt;
    bit stall_done, granted, idle_again;
    base = seq[1]; nwr = 0; stall_cnt = 0; stall_done = 0; granted = 0; idle_again = 0;
    bus.clear_i = 1'b0; bus.fifo_full_i = 1'b0; bus.valid_i = '1; bus.len_i[1] = 8'd7; bus.req_i = 3'b010;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (bus.gnt_o != '0) granted = 1;
      if (granted && !bus.busy_o) begin idle_again = 1; break; end
      if (bus.fifo_full_i) begin
        checks++; if (bus.ready_o !== 3'b000) begin failures++; $display("[TB] FAIL stall_ready cyc %0d: got %b expected 000", cyc, bus.ready_o); end
        checks++; if (bus.fifo_write_o !== 1'b0) begin failures++; $display("[TB] FAIL stall_write cyc %0d: got %b expected 0", cyc, bus.fifo_write_o); end
      end
      if (bus.fifo_write_o) begin
        checks++; if (bus.fifo_data_o !== mk(1, base + nwr)) begin failures++; $display("[TB] FAIL stall_data beat %0d: got %h expected %h", nwr, bus.fifo_data_o, mk(1, base + nwr)); end
        nwr++;
      end
      edge_step();
      if (granted) bus.req_i = '0;
      if (stall_cnt > 0) begin
        stall_cnt--;
        if (stall_cnt == 0) bus.fifo_full_i = 1'b0;
      end else if (nwr == 3 && !stall_done) begin
        bus.fifo_full_i = 1'b1;
        stall_cnt = 5;
        stall_done = 1;
      end
    end
    if (idle_again) edge_step();
    checks++; if (nwr != 8) begin failures++; $display("[TB] FAIL stall_count: got %0d writes expected 8", nwr); end
    checks++; if (!idle_again) begin failures++; $display("[TB] FAIL stall_end: got burst unfinished expected idle"); end
    bus.fifo_full_i = 1'b0;
  endtask

  task automatic test_clear();
    int nwr;
    bit seen, ok;
    bus.valid_i = '1; bus.fifo_full_i = 1'b0; bus.clear_i = 1'b0;
    bus.len_i[0] = 8'd0; bus.req_i = 3'b001; seen = 0;
    for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
      @(negedge clk);
      if (bus.fifo_write_o) seen = 1;
      edge_step();
    end
    drain(ok);
    checks++; if (!seen || !ok) begin failures++; $display("[TB] FAIL clear_warmup: got seen=%0d idle=%0d expected 1 1", seen, ok); end
    bus.len_i[0] = 8'd5; bus.req_i = 3'b001; nwr = 0;
    for (int cyc = 0; cyc < 20 && nwr < 2; cyc++) begin
      @(negedge clk);
      if (bus.fifo_write_o) nwr++;
      edge_step();
    end
    checks++; if (nwr != 2) begin failures++; $display("[TB] FAIL clear_setup: got %0d writes expected 2", nwr); end
    bus.clear_i = 1'b1; bus.req_i = 3'b011;
    @(negedge clk);
    checks++; if (bus.fifo_write_o !== 1'b0) begin failures++; $display("[TB] FAIL clear_write: got %b expected 0", bus.fifo_write_o); end
    checks++; if (bus.ready_o !== 3'b000) begin failures++; $display("[TB] FAIL clear_ready: got %b expected 000", bus.ready_o); end
    edge_step();
    bus.clear_i = 1'b0;
    @(negedge clk);
    checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("[TB] FAIL clear_idle_busy: got %b expected 0", bus.busy_o); end
    checks++; if (bus.gnt_o !== 3'b000) begin failures++; $display("[TB] FAIL clear_idle_gnt: got %b expected 000", bus.gnt_o); end
    edge_step();
    @(negedge clk);
    checks++; if (bus.gnt_o !== 3'b001) begin failures++; $display("[TB] FAIL clear_regrant: got %b expected 001", bus.gnt_o); end
    edge_step();
    drain(ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL clear_drain: got busy stuck expected idle"); end
  endtask

  task automatic test_async_reset();
    bit seen;
    seen = 0;
    bus.req_i = 3'b010; bus.len_i[1] = 8'd10; bus.valid_i = '1; bus.fifo_full_i = 1'b0; bus.clear_i = 1'b0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (bus.fifo_write_o) begin seen = 1; break; end
      edge_step();
    end
    checks++; if (!seen) begin failures++; $display("[TB] FAIL areset_setup: got no write expected burst in progress"); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("[TB] FAIL areset_busy: got %b expected 0", bus.busy_o); end
    checks++; if (bus.gnt_o !== 3'b000) begin failures++; $display("[TB] FAIL areset_gnt: got %b expected 000", bus.gnt_o); end
    checks++; if (bus.fifo_write_o !== 1'b0) begin failures++; $display("[TB] FAIL areset_write: got %b expected 0", bus.fifo_write_o); end
    checks++; if (bus.ready_o !== 3'b000) begin failures++; $display("[TB] FAIL areset_ready: got %b expected 000", bus.ready_o); end
    @(posedge clk);
    #1;
    bus.req_i = '0;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.fifo_write_o !== 1'b0) begin failures++; $display("[TB] FAIL areset_after_write: got %b expected 0", bus.fifo_write_o); end
    checks++; if (bus.gnt_o !== 3'b000) begin failures++; $display("[TB] FAIL areset_after_gnt: got %b expected 000", bus.gnt_o); end
    edge_step();
  endtask

  task automatic test_long_burst();
    int base, nwr;
    bit granted, done;
    base = seq[0]; nwr = 0; granted = 0; done = 0;
    bus.len_i[0] = 8'd255; bus.req_i = 3'b001; bus.fifo_full_i = 1'b0; bus.clear_i = 1'b0;
    bus.valid_i[0] = 1'($urandom_range(0, 1));
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      if (bus.gnt_o != '0) granted = 1;
      if (granted && !bus.busy_o) begin done = 1; break; end
      if (bus.fifo_write_o) begin
        checks++; if (bus.fifo_data_o !== mk(0, base + nwr)) begin failures++; $display("[TB] FAIL long_data beat %0d: got %h expected %h", nwr, bus.fifo_data_o, mk(0, base + nwr)); end
        nwr++;
      end
      edge_step();
      if (granted) bus.req_i = '0;
      bus.valid_i[0] = 1'($urandom_range(0, 1));
    end
    if (done) edge_step();
    checks++; if (nwr != 256) begin failures++; $display("[TB] FAIL long_count: got %0d writes expected 256", nwr); end
    checks++; if (!done) begin failures++; $display("[TB] FAIL long_end: got burst unfinished expected idle"); end
    bus.valid_i = '1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++; if (bus.fifo_write_o !== 1'b0) begin failures++; $display("[TB] FAIL long_extra_write cyc %0d: got %b expected 0", k, bus.fifo_write_o); end
      edge_step();
    end
  endtask

  task automatic test_random();
    int m_busy, m_owner, m_rem, m_last, rq;
    bit found, vo;
    logic [N-1:0] eg, er;
    logic [W-1:0] ed;
    logic ew;
    apply_reset();
    m_busy = 0; m_owner = 0; m_rem = 0; m_last = N - 1;
    rand_inputs();
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(negedge clk);
      vo = ((int'(bus.valid_i) >> m_owner) & 1) != 0;
      if (m_busy != 0) begin
        eg = N'(1) << m_owner;
        ed = mk(m_owner, seq[m_owner]);
      end else begin
        eg = '0;
        ed = '0;
      end
      er = (m_busy != 0 && !bus.clear_i && !bus.fifo_full_i) ? eg : '0;
      ew = (m_busy != 0) && !bus.clear_i && !bus.fifo_full_i && vo;
      checks++; if (bus.gnt_o !== eg) begin failures++; $display("[TB] FAIL rand_gnt cyc %0d: got %b expected %b", cyc, bus.gnt_o, eg); end
      checks++; if (bus.busy_o !== (m_busy != 0)) begin failures++; $display("[TB] FAIL rand_busy cyc %0d: got %b expected %0d", cyc, bus.busy_o, m_busy); end
      checks++; if (bus.ready_o !== er) begin failures++; $display("[TB] FAIL rand_ready cyc %0d: got %b expected %b", cyc, bus.ready_o, er); end
      checks++; if (bus.fifo_write_o !== ew) begin failures++; $display("[TB] FAIL rand_write cyc %0d: got %b expected %b", cyc, bus.fifo_write_o, ew); end
      checks++; if (bus.fifo_data_o !== ed) begin failures++; $display("[TB] FAIL rand_data cyc %0d: got %h expected %h", cyc, bus.fifo_data_o, ed); end
      if (bus.clear_i) begin
        m_busy = 0; m_rem = 0; m_last = N - 1;
      end else if (m_busy != 0) begin
        if (ew) begin
          m_rem--;
          if (m_rem == 0) begin m_busy = 0; m_last = m_owner; end
        end
      end else begin
        rq = int'(bus.req_i);
        found = 0;
        for (int k = 1; k <= N; k++) begin
          int c;
          c = (m_last + k) % N;
          if (!found && ((rq >> c) & 1) != 0) begin
            found = 1; m_owner = c; m_rem = lenv[c] + 1; m_busy = 1;
          end
        end
      end
      edge_step();
      rand_inputs();
    end
    bus.clear_i = 1'b0;
  endtask

  // Test sequence and summary.
  initial begin
    for (int c = 0; c < N; c++) seq[c] = 0;
    test_reset();
    test_single_burst();
    test_alternate();
    test_full_stall();
    test_clear();
    test_async_reset();
    test_long_burst();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
